fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameters SHALL be one per line (name, default, meaning):
  RESET_PC  32'h0000_0000  PC loaded at reset; bits [1:0] SHALL be treated as 0
  COUNT_WIDTH  16  width of the pushed-instruction counter
REQ-002 Ports SHALL be one per line (name, direction, width, meaning):
  clk  input  1  single clock, all state on posedge
  reset  input  1  synchronous, active-low reset
  imemReq_OUT  output  1  instruction-memory read request
  imemAddr_OUT  output  32  request address (word aligned)
  imemAck_IN  input  1  one-cycle response strobe, data valid same cycle
  imemData_IN  input  32  instruction word
  qPushReq_OUT  output  1  push to downstream instruction queue
  qData_OUT  output  64  {pc[31:0], instr[31:0]} pushed entry
  qFull_IN  input  1  downstream queue full flag
  qFlush_OUT  output  1  flush to downstream queue
  redirect_IN  input  1  one-cycle branch/exception redirect
  redirectPC_IN  input  32  redirect target
  pushCount_OUT  output  COUNT_WIDTH  count of accepted pushes
REQ-003 Clock SHALL be one clock, clk; reset SHALL be synchronous and active-low, on port reset.

Function
REQ-004 FSM states SHALL be IDLE, FETCH, PUSH, DRAIN; all outputs SHALL be registered.
REQ-005 IDLE SHALL last exactly one cycle after reset deasserts, then go to FETCH.
REQ-006 In FETCH: imemReq_OUT=1, imemAddr_OUT=pc; address held stable until imemAck_IN.
REQ-007 FETCH with imemAck_IN and no redirect: next cycle qData_OUT={pc, imemData_IN}, qPushReq_OUT=1, pc<=pc+4, imemReq_OUT=0, state PUSH.
REQ-008 qData_OUT SHALL be valid and stable in every cycle qPushReq_OUT=1.
REQ-009 In PUSH: a push SHALL be accepted at a posedge where qPushReq_OUT=1 and qFull_IN=0. On acceptance: qPushReq_OUT<=0, state FETCH, pushCount_OUT<=pushCount_OUT+1.
REQ-010 In PUSH with qFull_IN=1: qPushReq_OUT and qData_OUT SHALL hold, with no memory request, until qFull_IN=0.
REQ-011 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 0). pushCount_OUT SHALL wrap modulo 2^COUNT_WIDTH.
REQ-012 redirect_IN SHALL have priority over all other events except reset. It SHALL load pc<={redirectPC_IN[31:2],2'b00}. It SHALL set qFlush_OUT=1 for exactly the next cycle.
REQ-013 Redirect in PUSH: the pending entry SHALL be dropped (qPushReq_OUT<=0, no count increment), state FETCH.
REQ-014 Redirect in FETCH with imemAck_IN in the same cycle: the response SHALL be discarded, state FETCH at the new pc.
REQ-015 Redirect in FETCH without imemAck_IN: state DRAIN. imemReq_OUT and imemAddr_OUT SHALL hold the old request until imemAck_IN. That response SHALL be discarded, then state FETCH at the new pc.
REQ-016 Redirect in DRAIN SHALL update pc only and stay in DRAIN. Redirect in IDLE SHALL update pc; next state FETCH.
REQ-017 qPushReq_OUT SHALL be 0 in any cycle qFlush_OUT=1.
REQ-018 imemAck_IN outside FETCH/DRAIN SHALL be ignored.

Reset
REQ-019 With reset=0 at a posedge:
  - state IDLE, pc<=RESET_PC, all outputs 0 (imemAddr_OUT=RESET_PC, qData_OUT=0, pushCount_OUT=0)
  - reset overrides redirect_IN and imemAck_IN
  - a reset mid-PUSH or mid-DRAIN SHALL abandon the entry or request without a push.

Verification
REQ-020 Reset release, ack with 1-cycle latency, qFull_IN=0 -> pushes {0,instr} then {4,instr} on consecutive push cycles; pushCount_OUT=2.
REQ-021 qFull_IN=1 for 5 cycles in PUSH -> qPushReq_OUT=1 and qData_OUT stable for 5 cycles, imemReq_OUT=0; exactly one push after qFull_IN falls.
REQ-022 redirect_IN with redirectPC_IN=32'h0000_1003 while in PUSH -> qFlush_OUT=1 for one cycle with qPushReq_OUT=0; next request address=32'h0000_1000; count unchanged.
REQ-023 Redirect in FETCH, ack 3 cycles later -> imemAddr_OUT held at old pc through the ack; that data never pushed; next request at target.
REQ-024 pc=32'hFFFF_FFFC fetch accepted -> next imemAddr_OUT=0. 65536 pushes -> pushCount_OUT wraps to 0.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues single-word reads to instruction memory and
// pushes {pc, instr} pairs into a downstream queue. A redirect flushes the
// queue and restarts fetching at the new target. A request already issued
// when the redirect arrives is allowed to complete, and its response is then
// thrown away.
module fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   imemReq_OUT,
  output logic [31:0]            imemAddr_OUT,
  input  logic                   imemAck_IN,
  input  logic [31:0]            imemData_IN,
  output logic                   qPushReq_OUT,
  output logic [63:0]            qData_OUT,
  input  logic                   qFull_IN,
  output logic                   qFlush_OUT,
  input  logic                   redirect_IN,
  input  logic [31:0]            redirectPC_IN,
  output logic [COUNT_WIDTH-1:0] pushCount_OUT
);

  typedef enum logic [1:0] {IDLE, FETCH, PUSH, DRAIN} state_t;

  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  state_t                 state_q, state_d;
  logic [31:0]            pc_q, pc_d;
  logic                   imem_req_q, imem_req_d;
  logic [31:0]            imem_addr_q, imem_addr_d;
  logic                   q_push_q, q_push_d;
  logic [63:0]            q_data_q, q_data_d;
  logic                   q_flush_q, q_flush_d;
  logic [COUNT_WIDTH-1:0] push_count_q, push_count_d;
  logic [31:0]            redirect_pc;

  assign redirect_pc = {redirectPC_IN[31:2], 2'b00};

  // Next-state and next-output logic; every output is the image of a flop.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    imem_req_d   = imem_req_q;
    imem_addr_d  = imem_addr_q;
    q_push_d     = q_push_q;
    q_data_d     = q_data_q;
    q_flush_d    = 1'b0;
    push_count_d = push_count_q;
    case (state_q)
      IDLE: begin
        state_d    = FETCH;
        imem_req_d = 1'b1;
        if (redirect_IN) begin
          pc_d        = redirect_pc;
          q_flush_d   = 1'b1;
          imem_addr_d = redirect_pc;
        end else begin
          imem_addr_d = pc_q;
        end
      end
      FETCH: begin
        if (redirect_IN) begin
          pc_d      = redirect_pc;
          q_flush_d = 1'b1;
          if (imemAck_IN) begin
            // Response arrived with the redirect: drop it, refetch at target.
            imem_addr_d = redirect_pc;
          end else begin
            // Request still in flight: keep it on the bus until it returns.
            state_d = DRAIN;
          end
        end else if (imemAck_IN) begin
          q_data_d    = {pc_q, imemData_IN};
          q_push_d    = 1'b1;
          pc_d        = pc_q + 32'd4;
          imem_req_d  = 1'b0;
          imem_addr_d = pc_q + 32'd4;
          state_d     = PUSH;
        end
      end
      PUSH: begin
        if (redirect_IN) begin
          pc_d        = redirect_pc;
          q_flush_d   = 1'b1;
          q_push_d    = 1'b0;
          imem_req_d  = 1'b1;
          imem_addr_d = redirect_pc;
          state_d     = FETCH;
        end else if (!qFull_IN) begin
          q_push_d     = 1'b0;
          push_count_d = push_count_q + COUNT_WIDTH'(1);
          imem_req_d   = 1'b1;
          imem_addr_d  = pc_q;
          state_d      = FETCH;
        end
      end
      DRAIN: begin
        if (redirect_IN) begin
          pc_d      = redirect_pc;
          q_flush_d = 1'b1;
        end else if (imemAck_IN) begin
          // Stale response consumed; start the real fetch at the new pc.
          imem_addr_d = pc_q;
          state_d     = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC_ALIGNED;
      imem_req_q   <= 1'b0;
      imem_addr_q  <= RESET_PC_ALIGNED;
      q_push_q     <= 1'b0;
      q_data_q     <= 64'd0;
      q_flush_q    <= 1'b0;
      push_count_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      imem_req_q   <= imem_req_d;
      imem_addr_q  <= imem_addr_d;
      q_push_q     <= q_push_d;
      q_data_q     <= q_data_d;
      q_flush_q    <= q_flush_d;
      push_count_q <= push_count_d;
    end
  end

  assign imemReq_OUT   = imem_req_q;
  assign imemAddr_OUT  = imem_addr_q;
  assign qPushReq_OUT  = q_push_q;
  assign qData_OUT     = q_data_q;
  assign qFlush_OUT    = q_flush_q;
  assign pushCount_OUT = push_count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios with literal expectations, then
// randomized traffic, all compared cycle by cycle against a transaction-level
// model of the fetch/push/redirect rules.
module tb_fetch_unit;

  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          imemReq_OUT;
  logic [31:0]   imemAddr_OUT;
  logic          imemAck_IN;
  logic [31:0]   imemData_IN;
  logic          qPushReq_OUT;
  logic [63:0]   qData_OUT;
  logic          qFull_IN;
  logic          qFlush_OUT;
  logic          redirect_IN;
  logic [31:0]   redirectPC_IN;
  logic [CW-1:0] pushCount_OUT;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0003), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset),
    .imemReq_OUT(imemReq_OUT), .imemAddr_OUT(imemAddr_OUT),
    .imemAck_IN(imemAck_IN), .imemData_IN(imemData_IN),
    .qPushReq_OUT(qPushReq_OUT), .qData_OUT(qData_OUT), .qFull_IN(qFull_IN),
    .qFlush_OUT(qFlush_OUT), .redirect_IN(redirect_IN),
    .redirectPC_IN(redirectPC_IN), .pushCount_OUT(pushCount_OUT)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: m_busy = a read is on the bus, m_stale = that read is to be
  // discarded, m_start = first cycle out of reset.
  bit            m_start, m_stale, m_busy, m_hold, m_flush;
  logic [31:0]   m_pc, m_addr;
  logic [63:0]   m_entry;
  logic [CW-1:0] m_count;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model one clock using the inputs present at the edge.
  task automatic model_step();
    logic [31:0] tgt;
    tgt = {redirectPC_IN[31:2], 2'b00};
    if (!reset) begin
      m_start = 1; m_stale = 0; m_busy = 0; m_hold = 0; m_flush = 0;
      m_pc = 32'h0; m_addr = 32'h0; m_entry = 64'h0; m_count = '0;
      return;
    end
    m_flush = 0;
    if (redirect_IN) begin
      m_flush = 1;
      m_pc    = tgt;
      m_start = 0;
      if (m_busy && (m_stale || !imemAck_IN)) begin
        m_stale = 1;              // outstanding read stays on the bus
      end else begin
        m_hold = 0; m_busy = 1; m_stale = 0; m_addr = tgt;
      end
    end else if (m_start) begin
      m_start = 0; m_busy = 1; m_addr = m_pc;
    end else if (m_busy && imemAck_IN) begin
      if (m_stale) begin
        m_stale = 0; m_addr = m_pc;
      end else begin
        m_entry = {m_pc, imemData_IN};
        m_hold  = 1; m_busy = 0;
        m_pc    = m_pc + 32'd4;
        m_addr  = m_pc;
      end
    end else if (m_hold && !qFull_IN) begin
      $display("push pc=%h instr=%h count=%0d", m_entry[63:32], m_entry[31:0], m_count + 1'b1);
      m_hold = 0; m_count = m_count + 1'b1; m_busy = 1; m_addr = m_pc;
    end
  endtask

  task automatic cycle(input bit r, input bit a, input logic [31:0] d,
                       input bit f, input bit rd, input logic [31:0] rp);
    @(negedge clk);
    reset = r; imemAck_IN = a; imemData_IN = d; qFull_IN = f;
    redirect_IN = rd; redirectPC_IN = rp;
    @(posedge clk);
    model_step();
    #1;
    check("imemReq", 64'(imemReq_OUT), 64'(m_busy));
    check("imemAddr", 64'(imemAddr_OUT), 64'(m_addr));
    check("qPushReq", 64'(qPushReq_OUT), 64'(m_hold));
    check("qData", qData_OUT, m_entry);
    check("qFlush", 64'(qFlush_OUT), 64'(m_flush));
    check("pushCount", 64'(pushCount_OUT), 64'(m_count));
    if (qFlush_OUT && qPushReq_OUT) check("flush_excl_push", 64'd1, 64'd0);
  endtask

  task automatic idle_cyc(input int n);
    for (int i = 0; i < n; i++) cycle(1, 0, 32'h0, 0, 0, 32'h0);
  endtask

  initial begin
    reset = 0; imemAck_IN = 0; imemData_IN = 0; qFull_IN = 0;
    redirect_IN = 0; redirectPC_IN = 0;

    // Reset, including a redirect and ack that must be ignored.
    cycle(0, 0, 32'h0, 0, 0, 32'h0);
    cycle(0, 1, 32'hDEAD_BEEF, 0, 1, 32'h0000_5000);
    check("rst_addr", 64'(imemAddr_OUT), 64'h0);
    check("rst_req", 64'(imemReq_OUT), 64'h0);
    check("rst_count", 64'(pushCount_OUT), 64'h0);

    // Two fetches with one-cycle ack latency.
    cycle(1, 0, 32'h0, 0, 0, 32'h0);
    check("first_req", {imemReq_OUT, imemAddr_OUT}, {1'b1, 32'h0});
    cycle(1, 0, 32'h0, 0, 0, 32'h0);
    cycle(1, 1, 32'h1111_0001, 0, 0, 32'h0);
    check("push0", {qPushReq_OUT, qData_OUT}, {1'b1, 32'h0, 32'h1111_0001});
    cycle(1, 0, 32'h0, 0, 0, 32'h0);
    check("refetch_addr", 64'(imemAddr_OUT), 64'h4);
    cycle(1, 1, 32'h2222_0002, 0, 0, 32'h0);
    check("push1", {qPushReq_OUT, qData_OUT}, {1'b1, 32'h4, 32'h2222_0002});
    cycle(1, 0, 32'h0, 0, 0, 32'h0);
    check("count2", 64'(pushCount_OUT), 64'd2);

    // Queue full for five cycles holds the entry.
    cycle(1, 1, 32'h3333_0003, 1, 0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      cycle(1, 0, 32'h0, 1, 0, 32'h0);
      check("full_hold", {imemReq_OUT, qPushReq_OUT, qData_OUT},
            {1'b0, 1'b1, 32'h8, 32'h3333_0003});
    end
    cycle(1, 0, 32'h0, 0, 0, 32'h0);
    check("full_release", {qPushReq_OUT, 8'(pushCount_OUT)}, {1'b0, 8'd3});

    // Redirect while holding an entry: dropped, flushed, refetch aligned.
    cycle(1, 1, 32'h4444_0004, 1, 0, 32'h0);
    cycle(1, 0, 32'h0, 1, 1, 32'h0000_1003);
    check("redir_push", {qFlush_OUT, qPushReq_OUT, imemReq_OUT, imemAddr_OUT, 8'(pushCount_OUT)},
          {1'b1, 1'b0, 1'b1, 32'h0000_1000, 8'd3});
    cycle(1, 0, 32'h0, 0, 0, 32'h0);
    check("flush_one_cycle", 64'(qFlush_OUT), 64'd0);

    // Redirect with a read in flight: hold old address until ack, drop data.
    cycle(1, 0, 32'h0, 0, 1, 32'h0000_2000);
    check("drain_addr0", {imemReq_OUT, imemAddr_OUT}, {1'b1, 32'h0000_1000});
    idle_cyc(2);
    check("drain_addr2", {imemReq_OUT, imemAddr_OUT}, {1'b1, 32'h0000_1000});
    cycle(1, 1, 32'h5555_0005, 0, 0, 32'h0);
    check("drain_done", {qPushReq_OUT, imemReq_OUT, imemAddr_OUT}, {1'b0, 1'b1, 32'h0000_2000});

    // Redirect coinciding with ack, then pc wrap past the top of memory.
    cycle(1, 1, 32'h6666_0006, 0, 1, 32'hFFFF_FFFF);
    check("redir_ack", {qPushReq_OUT, imemAddr_OUT}, {1'b0, 32'hFFFF_FFFC});
    cycle(1, 1, 32'h7777_0007, 1, 0, 32'h0);
    check("wrap_entry", qData_OUT, {32'hFFFF_FFFC, 32'h7777_0007});
    check("wrap_addr", 64'(imemAddr_OUT), 64'h0);
    cycle(1, 0, 32'h0, 0, 0, 32'h0);
    check("wrap_refetch", {imemReq_OUT, imemAddr_OUT, 8'(pushCount_OUT)}, {1'b1, 32'h0, 8'd4});

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      bit a, r, rd;
      logic [31:0] rp;
      r  = ($urandom % 300) != 0;
      a  = m_busy ? (($urandom % 3) == 0) : (($urandom % 8) == 0);
      rd = ($urandom % 12) == 0;
      rp = (($urandom % 4) == 0) ? (32'hFFFF_FFF8 | 32'($urandom % 8)) : $urandom;
      cycle(r, a, $urandom, ($urandom % 3) == 0, rd, rp);
    end

    // Counter wrap: back-to-back pushes from reset.
    cycle(0, 0, 32'h0, 0, 0, 32'h0);
    cycle(1, 0, 32'h0, 0, 0, 32'h0);
    for (int i = 0; i < 256; i++) begin
      cycle(1, 1, 32'(i), 0, 0, 32'h0);
      cycle(1, 0, 32'h0, 0, 0, 32'h0);
      if (i == 254) check("count_255", 64'(pushCount_OUT), 64'd255);
    end
    check("count_wrap", 64'(pushCount_OUT), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
